vga_dac_palette: RTL

- Parametrised VGA DAC palette: CPU-side colour register file with a VGA-style index/data register interface and auto-increment, plus a pipelined pixel lookup port.
- Successor to the fixed 256x32 palette SRAM. Adds configurable entry count and component width, a pixel mask, triplet sequencing and a defined read/write collision rule.
- Sits between the CPU I/O decoder and the video output stage.

---
 rtl/vga_dac_palette.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/vga_dac_palette.sv
// VGA DAC colour palette: VGA-style index/data CPU register interface with
// auto-incrementing triplet sequencers, plus a two-stage pixel lookup pipeline.
module vga_dac_palette #(
    parameter int ENTRIES    = 256,
    parameter int COMP_WIDTH = 6,
    parameter int IDX_W      = $clog2(ENTRIES)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cpu_sel,
    input  logic                    cpu_we,
    input  logic [1:0]              cpu_addr,
    input  logic [7:0]              cpu_din,
    output logic [7:0]              cpu_dout,
    input  logic                    pix_en,
    input  logic [IDX_W-1:0]        pix_idx,
    output logic [3*COMP_WIDTH-1:0] pix_rgb,
    output logic                    pix_valid
);

    localparam int RGB_W = 3 * COMP_WIDTH;

    typedef enum logic {
        MODE_WRITE = 1'b0,
        MODE_READ  = 1'b1
    } mode_t;

    logic [RGB_W-1:0]      palette [ENTRIES];
    logic [IDX_W-1:0]      mask;
    logic [IDX_W-1:0]      rd_idx;
    logic [IDX_W-1:0]      wr_idx;
    logic [1:0]            rd_comp;
    logic [1:0]            wr_comp;
    mode_t                 mode;
    logic [COMP_WIDTH-1:0] hold_r;
    logic [COMP_WIDTH-1:0] hold_g;
    logic [IDX_W-1:0]      s1_idx;
    logic                  s1_en;

    logic                  cpu_wr;
    logic                  cpu_rd;
    logic                  commit;
    logic [IDX_W-1:0]      new_idx;
    logic [COMP_WIDTH-1:0] new_comp;
    logic [RGB_W-1:0]      rd_word;
    logic [COMP_WIDTH-1:0] rd_comp_val;
    logic [7:0]            rd_data;

    assign cpu_wr   = cpu_sel & cpu_we;
    assign cpu_rd   = cpu_sel & ~cpu_we;
    assign new_idx  = cpu_din[IDX_W-1:0];
    assign new_comp = cpu_din[COMP_WIDTH-1:0];
    assign commit   = cpu_wr && (cpu_addr == 2'd3) && (wr_comp == 2'd2) && !reset;
    assign rd_word  = palette[rd_idx];

    always_comb begin
        rd_comp_val = rd_word[COMP_WIDTH-1:0];
        case (rd_comp)
            2'd0:    rd_comp_val = rd_word[RGB_W-1:2*COMP_WIDTH];
            2'd1:    rd_comp_val = rd_word[2*COMP_WIDTH-1:COMP_WIDTH];
            default: rd_comp_val = rd_word[COMP_WIDTH-1:0];
        endcase
    end

    always_comb begin
        rd_data = 8'h00;
        case (cpu_addr)
            2'd0:    rd_data = 8'(mask);
            2'd1:    rd_data = (mode == MODE_READ) ? 8'h03 : 8'h00;
            2'd2:    rd_data = 8'(wr_idx);
            default: rd_data = 8'(rd_comp_val);
        endcase
    end

    // Palette contents are deliberately not reset; B completes the triplet.
    always_ff @(posedge clk) begin
        if (commit) begin
            palette[wr_idx] <= {hold_r, hold_g, new_comp};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_dout <= 8'h00;
            mask     <= '1;
            rd_idx   <= '0;
            wr_idx   <= '0;
            rd_comp  <= 2'd0;
            wr_comp  <= 2'd0;
            mode     <= MODE_WRITE;
            hold_r   <= '0;
            hold_g   <= '0;
        end else if (cpu_wr) begin
            case (cpu_addr)
                2'd0: mask <= new_idx;
                2'd1: begin
                    rd_idx  <= new_idx;
                    rd_comp <= 2'd0;
                    mode    <= MODE_READ;
                end
                2'd2: begin
                    wr_idx  <= new_idx;
                    wr_comp <= 2'd0;
                    mode    <= MODE_WRITE;
                    hold_r  <= '0;
                    hold_g  <= '0;
                end
                default: begin
                    case (wr_comp)
                        2'd0: begin
                            hold_r  <= new_comp;
                            wr_comp <= 2'd1;
                        end
                        2'd1: begin
                            hold_g  <= new_comp;
                            wr_comp <= 2'd2;
                        end
                        default: begin
                            wr_idx  <= wr_idx + 1'b1;
                            wr_comp <= 2'd0;
                        end
                    endcase
                end
            endcase
        end else if (cpu_rd) begin
            cpu_dout <= rd_data;
            if (cpu_addr == 2'd3) begin
                if (rd_comp == 2'd2) begin
                    rd_comp <= 2'd0;
                    rd_idx  <= rd_idx + 1'b1;
                end else begin
                    rd_comp <= rd_comp + 2'd1;
                end
            end
        end
    end

    // Stage 2 reads the array before a same-edge commit lands (read-before-write).
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_idx    <= '0;
            s1_en     <= 1'b0;
            pix_rgb   <= '0;
            pix_valid <= 1'b0;
        end else begin
            s1_idx    <= pix_idx & mask;
            s1_en     <= pix_en;
            pix_valid <= s1_en;
            if (s1_en) begin
                pix_rgb <= palette[s1_idx];
            end
        end
    end

endmodule
